// File: rtl/host_cmd_ctrl.sv
// Host command interpreter: pops READ/WRITE command bytes from the rx FIFO, drives the 16-bit register bus, and returns read data through the tx FIFO.
// Each byte pop takes 2 cycles. Waits in IDLE while rx is empty and stalls in TXH/TXL while tx is full.
module host_cmd_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_rd,
  output logic        rx_re,
  input  logic        rx_emp,
  input  logic        rx_aemp,
  output logic [7:0]  tx_wd,
  output logic        tx_we,
  input  logic        tx_ful,
  input  logic        tx_aful,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [15:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPT  = 3'd1,
    EXEC  = 3'd2,
    RWAIT = 3'd3,
    TXH   = 3'd4,
    TXL   = 3'd5
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic        is_wr;
  logic [3:0]  lat_cnt;
  logic [15:0] hold;
  logic        rx_re_q;
  logic        tx_we_q;
  logic        rd_busy;
  logic        wr_busy;
  logic        op_valid;
  logic        cmd_done;
  logic        lat_last;

  // The almost-empty/full terms use last cycle's strobe: that pop or push may not be reflected in the flags yet.
  assign rd_busy  = rx_emp | (rx_aemp & rx_re_q);
  assign wr_busy  = tx_ful | (tx_aful & tx_we_q);
  assign op_valid = (rx_rd == 8'h00) | (rx_rd == 8'h01);
  assign cmd_done = is_wr ? (cnt == 3'd4) : (cnt == 3'd2);
  assign lat_last = (lat_cnt == LAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rd_busy) state_nxt = CAPT;
      CAPT:    state_nxt = cmd_done ? EXEC : IDLE;
      EXEC:    state_nxt = is_wr ? IDLE : RWAIT;
      RWAIT:   if (lat_last) state_nxt = TXH;
      TXH:     if (!wr_busy) state_nxt = TXL;
      TXL:     if (!wr_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_re  = 1'b0;
    tx_we  = 1'b0;
    tx_wd  = hold[15:8];
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    busy   = (cnt != 3'd0) | ((state != IDLE) & (state != CAPT));
    case (state)
      IDLE: rx_re = !rd_busy & !rst;
      EXEC: begin
        bus_wr = is_wr;
        bus_rd = !is_wr;
      end
      TXH:  tx_we = !wr_busy;
      TXL: begin
        tx_we = !wr_busy;
        tx_wd = hold[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      is_wr     <= 1'b0;
      lat_cnt   <= 4'd0;
      hold      <= 16'h0000;
      bus_addr  <= 16'h0000;
      bus_wdata <= 16'h0000;
      rx_re_q   <= 1'b0;
      tx_we_q   <= 1'b0;
    end else begin
      rx_re_q <= rx_re;
      tx_we_q <= tx_we;
      case (state)
        CAPT: begin
          // An unknown opcode leaves the counter at 0 so the next byte is again an opcode.
          if (cnt != 3'd0 || op_valid) cnt <= cnt + 3'd1;
          case (cnt)
            3'd0: is_wr <= rx_rd[0];
            3'd1: bus_addr[15:8]  <= rx_rd;
            3'd2: bus_addr[7:0]   <= rx_rd;
            3'd3: bus_wdata[15:8] <= rx_rd;
            3'd4: bus_wdata[7:0]  <= rx_rd;
            default: ;
          endcase
        end
        EXEC: begin
          lat_cnt <= 4'd0;
          if (is_wr) cnt <= 3'd0;
        end
        RWAIT: begin
          lat_cnt <= lat_cnt + 4'd1;
          if (lat_last) hold <= bus_rdata;
        end
        TXL: if (!wr_busy) cnt <= 3'd0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Bench for host_cmd_ctrl: FIFO and register-bus models around the DUT, directed scenarios plus a randomized command stream.
module tb_host_cmd_ctrl;
  localparam int RD_LAT = 1;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_rd = 8'h00;
  logic        rx_re;
  logic        rx_emp = 1'b1;
  logic        rx_aemp = 1'b0;
  logic [7:0]  tx_wd;
  logic        tx_we;
  logic        tx_ful = 1'b0;
  logic        tx_aful = 1'b0;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] bus_rdata;
  logic        busy;

  host_cmd_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .rx_rd(rx_rd), .rx_re(rx_re), .rx_emp(rx_emp), .rx_aemp(rx_aemp),
    .tx_wd(tx_wd), .tx_we(tx_we), .tx_ful(tx_ful), .tx_aful(tx_aful),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  int          tx_cyc[$];
  logic [31:0] wrq[$];
  logic [15:0] rdq[$];
  int          rd_cyc_q[$];
  int          wr_gap[$];
  logic [15:0] sregs[logic [15:0]];
  logic [15:0] mregs[logic [15:0]];
  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          cyc = 0;
  int          viol = 0;
  int          txcnt = 0;
  int          rd_cyc = -100;
  int          last_pop = -100;
  int          drain_pct = 50;
  logic [15:0] rd_val = 16'h0000;
  logic        force_full = 1'b0;
  logic        prev_pop = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Register slave returns valid data only on the cycle RD_LAT after the read strobe.
  assign bus_rdata = (cyc == rd_cyc + RD_LAT) ? rd_val : 16'hDEAD;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  always begin : env_model
    logic p, w, f, bw, br;
    logic [7:0] wd;
    logic [15:0] ba, bd;
    int c;
    @(posedge clk);
    p = rx_re; w = tx_we; f = tx_ful; wd = tx_wd;
    bw = bus_wr; br = bus_rd; ba = bus_addr; bd = bus_wdata; c = cyc;
    #1;
    cyc = c + 1;
    if (p) begin
      if (prev_pop || rxq.size() == 0) viol++;
      last_pop = c;
    end
    if (p && rxq.size() != 0) rx_rd = rxq.pop_front();
    else rx_rd = 8'($urandom);
    prev_pop = p;
    rx_emp  = (rxq.size() == 0);
    rx_aemp = (rxq.size() == 1);
    if (w) begin
      if (f || txcnt >= 4) viol++;
      txq.push_back(wd);
      tx_cyc.push_back(c);
      txcnt++;
    end
    if (txcnt > 0 && $urandom_range(0, 99) < drain_pct) txcnt--;
    tx_ful  = force_full || (txcnt >= 4);
    tx_aful = (txcnt == 3);
    if (bw) begin
      if (prev_wr) viol++;
      wrq.push_back({ba, bd});
      wr_gap.push_back(c - last_pop);
      sregs[ba] = bd;
    end
    if (br) begin
      if (prev_rd) viol++;
      rdq.push_back(ba);
      rd_cyc_q.push_back(c);
      rd_cyc = c;
      rd_val = sregs.exists(ba) ? sregs[ba] : dflt(ba);
    end
    prev_wr = bw;
    prev_rd = br;
  end

  task automatic clear_obs();
    txq.delete(); tx_cyc.delete(); wrq.delete(); rdq.delete();
    rd_cyc_q.delete(); wr_gap.delete(); viol = 0;
  endtask

  task automatic push_bytes(input bq_t b);
    foreach (b[i]) rxq.push_back(b[i]);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (rxq.size() == 0 && !busy && !tx_we) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s_timeout busy=%0b rxq=%0d required idle within 3000 cycles", name, busy, rxq.size());
    end
  endtask

  task automatic check_viol(input string name);
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL %s_protocol violations=%0d required 0", name, viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (rx_re !== 1'b0)       begin errors++; $display("FAIL rst_rx_re got %b want 0", rx_re); end
    if (tx_we !== 1'b0)       begin errors++; $display("FAIL rst_tx_we got %b want 0", tx_we); end
    if (bus_wr !== 1'b0)      begin errors++; $display("FAIL rst_bus_wr got %b want 0", bus_wr); end
    if (bus_rd !== 1'b0)      begin errors++; $display("FAIL rst_bus_rd got %b want 0", bus_rd); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (tx_wd !== 8'h00)      begin errors++; $display("FAIL rst_tx_wd got %h want 00", tx_wd); end
    if (bus_addr !== 16'h0)   begin errors++; $display("FAIL rst_bus_addr got %h want 0000", bus_addr); end
    if (bus_wdata !== 16'h0)  begin errors++; $display("FAIL rst_bus_wdata got %h want 0000", bus_wdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    clear_obs();
    push_bytes('{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD});
    wait_idle("write");
    checks += 4;
    if (wrq.size() !== 1) begin errors++; $display("FAIL write_count got %0d want 1", wrq.size()); end
    else if (wrq[0] !== 32'h1234ABCD) begin errors++; $display("FAIL write_addr_data got %h want 1234abcd", wrq[0]); end
    if (txq.size() + rdq.size() !== 0) begin errors++; $display("FAIL write_no_tx_rd got %0d want 0", txq.size() + rdq.size()); end
    if (wr_gap.size() == 0 || wr_gap[0] !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", wr_gap.size() ? wr_gap[0] : -1); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after got %b want 0", busy); end
    check_viol("write");
  endtask

  task automatic test_read();
    clear_obs();
    sregs[16'h0010] = 16'h5A3C;
    push_bytes('{8'h00, 8'h00, 8'h10});
    wait_idle("read");
    checks += 5;
    if (rdq.size() !== 1 || rdq[0] !== 16'h0010) begin errors++; $display("FAIL read_addr got n=%0d a=%h want 1 x 0010", rdq.size(), rdq.size() ? rdq[0] : 16'hx); end
    if (txq.size() !== 2) begin errors++; $display("FAIL read_tx_count got %0d want 2", txq.size()); end
    else if (txq[0] !== 8'h5A || txq[1] !== 8'h3C) begin errors++; $display("FAIL read_tx_bytes got %h %h want 5a 3c", txq[0], txq[1]); end
    if (tx_cyc.size() == 0 || rd_cyc_q.size() == 0 || tx_cyc[0] - rd_cyc_q[0] !== RD_LAT + 1) begin
      errors++; $display("FAIL read_latency got %0d want %0d", (tx_cyc.size() && rd_cyc_q.size()) ? tx_cyc[0] - rd_cyc_q[0] : -1, RD_LAT + 1);
    end
    if (wrq.size() !== 0) begin errors++; $display("FAIL read_no_write got %0d want 0", wrq.size()); end
    if (tx_cyc.size() == 2 && tx_cyc[1] - tx_cyc[0] !== 1) begin errors++; $display("FAIL read_tx_spacing got %0d want 1", tx_cyc[1] - tx_cyc[0]); end
    check_viol("read");
  endtask

  task automatic test_invalid();
    clear_obs();
    push_bytes('{8'h7F, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02});
    wait_idle("invalid");
    checks += 2;
    if (wrq.size() !== 1 || wrq[0] !== 32'h00010002) begin errors++; $display("FAIL invalid_write got n=%0d v=%h want 1 x 00010002", wrq.size(), wrq.size() ? wrq[0] : 32'hx); end
    if (txq.size() + rdq.size() !== 0) begin errors++; $display("FAIL invalid_no_tx_rd got %0d want 0", txq.size() + rdq.size()); end
    check_viol("invalid");
  endtask

  task automatic test_tx_stall();
    int low = 0;
    clear_obs();
    force_full = 1'b1;
    push_bytes('{8'h00, 8'h12, 8'h34});
    repeat (30) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) low++;
    end
    checks += 2;
    if (txq.size() !== 0) begin errors++; $display("FAIL stall_no_push got %0d want 0", txq.size()); end
    if (low !== 0) begin errors++; $display("FAIL stall_busy low_cycles=%0d want 0", low); end
    force_full = 1'b0;
    wait_idle("stall");
    checks++;
    if (txq.size() !== 2 || txq[0] !== 8'hAB || txq[1] !== 8'hCD) begin
      errors++; $display("FAIL stall_tx_bytes got n=%0d want ab cd", txq.size());
    end
    check_viol("stall");
  endtask

  task automatic test_gap();
    int low = 0;
    clear_obs();
    push_bytes('{8'h01, 8'h12});
    repeat (10) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) low++;
    end
    checks++;
    if (low !== 0) begin errors++; $display("FAIL gap_busy low_cycles=%0d want 0", low); end
    push_bytes('{8'h34, 8'hAB, 8'hCD});
    wait_idle("gap");
    checks++;
    if (wrq.size() !== 1 || wrq[0] !== 32'h1234ABCD) begin errors++; $display("FAIL gap_write got n=%0d v=%h want 1 x 1234abcd", wrq.size(), wrq.size() ? wrq[0] : 32'hx); end
    check_viol("gap");
  endtask

  task automatic test_mid_reset();
    clear_obs();
    push_bytes('{8'h01, 8'h56, 8'h78});
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus_addr !== 16'h5678) begin errors++; $display("FAIL midrst_partial busy=%b addr=%h want 1 5678", busy, bus_addr); end
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (bus_addr !== 16'h0000) begin errors++; $display("FAIL midrst_addr got %h want 0000", bus_addr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if ({rx_re, tx_we, bus_wr, bus_rd} !== 4'b0) begin errors++; $display("FAIL midrst_strobes got %b want 0000", {rx_re, tx_we, bus_wr, bus_rd}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_bytes('{8'h00, 8'h00, 8'h05});
    wait_idle("midrst");
    checks += 3;
    if (rdq.size() !== 1 || rdq[0] !== 16'h0005) begin errors++; $display("FAIL midrst_read_addr got n=%0d a=%h want 1 x 0005", rdq.size(), rdq.size() ? rdq[0] : 16'hx); end
    if (wrq.size() !== 0) begin errors++; $display("FAIL midrst_no_write got %0d want 0", wrq.size()); end
    if (txq.size() !== 2 || txq[0] !== 8'hC3 || txq[1] !== 8'hA0) begin errors++; $display("FAIL midrst_tx got n=%0d want c3 a0", txq.size()); end
    check_viol("midrst");
  endtask

  // Reference model: interpret the byte stream command by command against its own register image.
  task automatic model_run(input bq_t s);
    int i = 0;
    logic [15:0] a, d, v;
    while (i < s.size()) begin
      if (s[i] == 8'h00 && i + 2 < s.size()) begin
        a = {s[i+1], s[i+2]};
        v = mregs.exists(a) ? mregs[a] : dflt(a);
        exp_rd.push_back(a);
        exp_tx.push_back(v[15:8]);
        exp_tx.push_back(v[7:0]);
        i += 3;
      end else if (s[i] == 8'h01 && i + 4 < s.size()) begin
        a = {s[i+1], s[i+2]};
        d = {s[i+3], s[i+4]};
        mregs[a] = d;
        exp_wr.push_back({a, d});
        i += 5;
      end else if (s[i] == 8'h00 || s[i] == 8'h01) begin
        break;
      end else begin
        i += 1;
      end
    end
  endtask

  task automatic test_random();
    bq_t s;
    logic [15:0] pool[4] = '{16'h0000, 16'h1234, 16'hFFFF, 16'h8001};
    logic [15:0] a, d;
    int idx = 0;
    clear_obs();
    sregs.delete(); mregs.delete();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    for (int k = 0; k < 40; k++) begin
      a = pool[$urandom_range(0, 3)];
      d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: s = {s, 8'h00, a[15:8], a[7:0]};
        1: s = {s, 8'h01, a[15:8], a[7:0], d[15:8], d[7:0]};
        default: s.push_back(8'($urandom_range(2, 255)));
      endcase
    end
    model_run(s);
    drain_pct = 20;
    while (idx < s.size()) begin
      @(negedge clk);
      force_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        rxq.push_back(s[idx]);
        idx++;
      end
    end
    @(negedge clk);
    force_full = 1'b0;
    wait_idle("random");
    drain_pct = 50;
    checks += 3;
    if (wrq.size() !== exp_wr.size()) begin errors++; $display("FAIL rand_wr_count got %0d want %0d", wrq.size(), exp_wr.size()); end
    if (rdq.size() !== exp_rd.size()) begin errors++; $display("FAIL rand_rd_count got %0d want %0d", rdq.size(), exp_rd.size()); end
    if (txq.size() !== exp_tx.size()) begin errors++; $display("FAIL rand_tx_count got %0d want %0d", txq.size(), exp_tx.size()); end
    for (int i = 0; i < exp_wr.size() && i < wrq.size(); i++) begin
      checks++;
      if (wrq[i] !== exp_wr[i]) begin errors++; $display("FAIL rand_wr[%0d] got %h want %h", i, wrq[i], exp_wr[i]); end
    end
    for (int i = 0; i < exp_rd.size() && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i] !== exp_rd[i]) begin errors++; $display("FAIL rand_rd[%0d] got %h want %h", i, rdq[i], exp_rd[i]); end
    end
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== exp_tx[i]) begin errors++; $display("FAIL rand_tx[%0d] got %h want %h", i, txq[i], exp_tx[i]); end
    end
    check_viol("random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_tx_stall();
    test_gap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
